// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the retire-to-regfile writeback queue
//
// Purpose : register-index / data widths, the x0 index constant and the queued
//           entry type used by regfile_writer and regfile_writer_bypass.
// Ports   : none (package).
package regfile_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Writes to x0 are architecturally discarded.
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_bypass.sv
// rtl/regfile_writer_bypass.sv - youngest-match lookup of one read port into the writeback queue
//
// Purpose : combinationally search the valid queue entries for i_addr and return
//           the data of the youngest match; never hits on x0.
// Ports   : i_q       queue storage (all DEPTH slots)
//           i_rd_ptr  slot index of the oldest valid entry
//           i_count   number of valid entries
//           i_addr    register index being read
//           o_hit     a valid entry for i_addr is queued
//           o_data    data of the youngest matching entry (0 when no hit)
module regfile_writer_bypass
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  wb_entry_t [DEPTH-1:0]      i_q,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_ptr,
    input  logic [$clog2(DEPTH):0]     i_count,
    input  logic [REG_W-1:0]           i_addr,
    output logic                       o_hit,
    output logic [DATA_W-1:0]          o_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] w_idx;

    // Walk from oldest to youngest so that a later (younger) match overrides.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PW'(i);
            if ((CW'(i) < i_count) && (i_addr != REG_X0) && (i_q[w_idx].addr == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_q[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - two-wide retire queue draining into a two-write-port register file
//
// Purpose : accepts up to two retire results per cycle (in0 older than in1),
//           drops x0 writes, queues the rest and drains up to two per cycle onto
//           the regfile write ports, coalescing same-address pairs so both ports
//           never target one register.
// Config  : define WB_BYPASS_EN to add four read-bypass lookup ports.
// Ports   : clk, rst                  clock, asynchronous active-high reset
//           inN_valid/addr/data       retire slots (N = 0, 1)
//           in_ready                  both slots may be presented this cycle
//           we1/w_addr1/w_data1       regfile write port 1
//           we2/w_addr2/w_data2       regfile write port 2
//           byp_addrK/hitK/dataK      bypass lookups, K = 0..3 (WB_BYPASS_EN only)
//           count, empty              queue occupancy
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in0_valid,
    input  logic [REG_W-1:0]         in0_addr,
    input  logic [DATA_W-1:0]        in0_data,
    input  logic                     in1_valid,
    input  logic [REG_W-1:0]         in1_addr,
    input  logic [DATA_W-1:0]        in1_data,
    output logic                     in_ready,
    output logic                     we1,
    output logic [REG_W-1:0]         w_addr1,
    output logic [DATA_W-1:0]        w_data1,
    output logic                     we2,
    output logic [REG_W-1:0]         w_addr2,
    output logic [DATA_W-1:0]        w_data2,
`ifdef WB_BYPASS_EN
    input  logic [REG_W-1:0]         byp_addr0,
    input  logic [REG_W-1:0]         byp_addr1,
    input  logic [REG_W-1:0]         byp_addr2,
    input  logic [REG_W-1:0]         byp_addr3,
    output logic                     byp_hit0,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic                     byp_hit3,
    output logic [DATA_W-1:0]        byp_data0,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [DATA_W-1:0]        byp_data3,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] r_q;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_push0;
    logic                  w_push1;
    logic [1:0]            w_push_n;
    logic [1:0]            w_pop_n;
    logic [PW-1:0]         w_wr_ptr1;
    logic [PW-1:0]         w_rd_ptr1;
    wb_entry_t             w_h0;
    wb_entry_t             w_h1;

    // Room for two pushes is guaranteed even before this cycle's drain is counted.
    assign in_ready = (r_count <= CW'(DEPTH - 2));

    assign w_push0  = in0_valid && in_ready && (in0_addr != REG_X0);
    assign w_push1  = in1_valid && in_ready && (in1_addr != REG_X0);
    assign w_push_n = {1'b0, w_push0} + {1'b0, w_push1};

    // The regfile never stalls: drain as much as the two ports allow.
    assign w_pop_n  = (r_count == '0)      ? 2'd0 :
                      (r_count == CW'(1))  ? 2'd1 : 2'd2;

    // in1 lands behind in0 only when in0 was actually queued.
    assign w_wr_ptr1 = r_wr_ptr + PW'(w_push0);
    assign w_rd_ptr1 = r_rd_ptr + PW'(1);

    assign w_h0 = r_q[r_rd_ptr];
    assign w_h1 = r_q[w_rd_ptr1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push0) begin
                r_q[r_wr_ptr] <= '{addr: in0_addr, data: in0_data};
            end
            if (w_push1) begin
                r_q[w_wr_ptr1] <= '{addr: in1_addr, data: in1_data};
            end
        end
    end

    // Same-address pair: the younger value is the only one that matters, so it
    // goes out alone on port 1 and both entries retire together.
    always_comb begin
        we1     = 1'b0;
        we2     = 1'b0;
        w_addr1 = w_h0.addr;
        w_data1 = w_h0.data;
        w_addr2 = w_h1.addr;
        w_data2 = w_h1.data;
        if (r_count == CW'(1)) begin
            we1 = 1'b1;
        end else if (r_count >= CW'(2)) begin
            we1 = 1'b1;
            if (w_h0.addr == w_h1.addr) begin
                w_addr1 = w_h1.addr;
                w_data1 = w_h1.data;
            end else begin
                we2 = 1'b1;
            end
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);

`ifdef WB_BYPASS_EN
    logic [3:0][REG_W-1:0]  w_byp_addr;
    logic [3:0]             w_byp_hit;
    logic [3:0][DATA_W-1:0] w_byp_data;

    assign w_byp_addr = {byp_addr3, byp_addr2, byp_addr1, byp_addr0};
    assign {byp_hit3, byp_hit2, byp_hit1, byp_hit0}     = w_byp_hit;
    assign {byp_data3, byp_data2, byp_data1, byp_data0} = w_byp_data;

    for (genvar k = 0; k < 4; k++) begin : g_byp
        regfile_writer_bypass #(
            .DEPTH (DEPTH)
        ) u_byp (
            .i_q      (r_q),
            .i_rd_ptr (r_rd_ptr),
            .i_count  (r_count),
            .i_addr   (w_byp_addr[k]),
            .o_hit    (w_byp_hit[k]),
            .o_data   (w_byp_data[k])
        );
    end
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - scoreboard bench for regfile_writer
module tb_regfile_writer;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in0_valid, in1_valid;
    logic [4:0]              in0_addr, in1_addr;
    logic [31:0]             in0_data, in1_data;
    logic                    in_ready;
    logic                    we1, we2;
    logic [4:0]              w_addr1, w_addr2;
    logic [31:0]             w_data1, w_data2;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;
`ifdef WB_BYPASS_EN
    logic [4:0]              byp_addr0, byp_addr1, byp_addr2, byp_addr3;
    logic                    byp_hit0, byp_hit1, byp_hit2, byp_hit3;
    logic [31:0]             byp_data0, byp_data1, byp_data2, byp_data3;
`endif

    int   total = 0;
    int   bad   = 0;
    int   m_count = 0;
    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;

    regfile_writer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_addr  (in0_addr),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_addr  (in1_addr),
        .in1_data  (in1_data),
        .in_ready  (in_ready),
        .we1       (we1),
        .w_addr1   (w_addr1),
        .w_data1   (w_data1),
        .we2       (we2),
        .w_addr2   (w_addr2),
        .w_data2   (w_data2),
`ifdef WB_BYPASS_EN
        .byp_addr0 (byp_addr0),
        .byp_addr1 (byp_addr1),
        .byp_addr2 (byp_addr2),
        .byp_addr3 (byp_addr3),
        .byp_hit0  (byp_hit0),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_hit3  (byp_hit3),
        .byp_data0 (byp_data0),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
        .byp_data3 (byp_data3),
`endif
        .count     (count),
        .empty     (empty)
    );

    // Write-port monitor: every observed write must be the next expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (we1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL mon_we1_unexpected got addr=%0d data=%h required no write", w_addr1, w_data1);
                end else begin
                    m_e = sb.pop_front();
                    if ({w_addr1, w_data1} !== {m_e.a, m_e.d}) begin
                        bad++;
                        $display("FAIL mon_port1 got addr=%0d data=%h required addr=%0d data=%h", w_addr1, w_data1, m_e.a, m_e.d);
                    end
                end
                total++;
                if (w_addr1 === 5'd0) begin
                    bad++;
                    $display("FAIL mon_x0_write got addr=%0d required nonzero", w_addr1);
                end
            end
            if (we2) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL mon_we2_unexpected got addr=%0d data=%h required no write", w_addr2, w_data2);
                end else begin
                    m_e = sb.pop_front();
                    if ({w_addr2, w_data2} !== {m_e.a, m_e.d}) begin
                        bad++;
                        $display("FAIL mon_port2 got addr=%0d data=%h required addr=%0d data=%h", w_addr2, w_data2, m_e.a, m_e.d);
                    end
                end
                total++;
                if (we1 && (w_addr1 === w_addr2)) begin
                    bad++;
                    $display("FAIL mon_same_addr got addr1=%0d addr2=%0d required different", w_addr1, w_addr2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        logic rdy, acc0, acc1;
        int   pushn, popn;
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        rdy  = (m_count <= DEPTH - 2);
        total++;
        if (in_ready !== rdy) begin
            bad++;
            $display("FAIL in_ready got %b required %b (model count %0d)", in_ready, rdy, m_count);
        end
        acc0 = v0 && rdy && (a0 != 5'd0);
        acc1 = v1 && rdy && (a1 != 5'd0);
        if (acc0 && acc1 && (a0 == a1)) begin
            sb.push_back('{a: a1, d: d1});
        end else begin
            if (acc0) sb.push_back('{a: a0, d: d0});
            if (acc1) sb.push_back('{a: a1, d: d1});
        end
        pushn = int'(acc0) + int'(acc1);
        popn  = (m_count >= 2) ? 2 : m_count;
        @(posedge clk);
        #1;
        m_count   = m_count + pushn - popn;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        total++;
        if (count !== m_count[$clog2(DEPTH):0]) begin
            bad++;
            $display("FAIL count got %0d required %0d", count, m_count);
        end
        total++;
        if (empty !== (m_count == 0)) begin
            bad++;
            $display("FAIL empty got %b required %b", empty, (m_count == 0));
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 8 && m_count != 0; k++) step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got %0d pending writes required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({count, empty, we1, we2, in_ready} !== {2'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got count=%0d empty=%b we1=%b we2=%b rdy=%b required 0 1 0 0 1",
                     count, empty, we1, we2, in_ready);
        end
    endtask

    task automatic test_pair();
        step(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
        total++;
        if ({we1, we2, w_addr1, w_data1, w_addr2, w_data2} !== {1'b1, 1'b1, 5'd5, 32'h11, 5'd6, 32'h22}) begin
            bad++;
            $display("FAIL pair_ports got we=%b%b p1=%0d/%h p2=%0d/%h required 11 5/11 6/22",
                     we1, we2, w_addr1, w_data1, w_addr2, w_data2);
        end
        step(0, 0, 0, 0, 0, 0);
        drain("pair");
    endtask

    task automatic test_coalesce();
        step(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
        total++;
        if ({we1, we2, w_addr1, w_data1} !== {1'b1, 1'b0, 5'd3, 32'hB}) begin
            bad++;
            $display("FAIL coalesce got we=%b%b p1=%0d/%h required 10 3/b", we1, we2, w_addr1, w_data1);
        end
        drain("coalesce");
    endtask

    task automatic test_x0();
        step(1, 5'd0, 32'hFF, 1, 5'd7, 32'h1);
        total++;
        if ({we1, we2, w_addr1, w_data1} !== {1'b1, 1'b0, 5'd7, 32'h1}) begin
            bad++;
            $display("FAIL x0_drop got we=%b%b p1=%0d/%h required 10 7/1", we1, we2, w_addr1, w_data1);
        end
        drain("x0");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step(1, 5'(2 * i + 1), $urandom, 1, 5'(2 * i + 2), $urandom);
            total++;
            if (count > DEPTH) begin
                bad++;
                $display("FAIL b2b_bound got count=%0d required <=%0d", count, DEPTH);
            end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        step(1, 5'd8, 32'h80, 1, 5'd9, 32'h90);
        #1;
        rst = 1'b1;
        in0_valid = 1'b1; in0_addr = 5'd10; in0_data = 32'hA0;
        sb.delete();
        m_count = 0;
        #1;
        total++;
        if ({we1, we2, count, empty} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_async got we=%b%b count=%0d empty=%b required 00 0 1", we1, we2, count, empty);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        in0_valid = 1'b0;
        rst = 1'b0;
        total++;
        if ({in_ready, count} !== {1'b1, 2'd0}) begin
            bad++;
            $display("FAIL reset_release got rdy=%b count=%0d required 1 0", in_ready, count);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        byp_addr1 = 5'd0; byp_addr2 = 5'd4; byp_addr3 = 5'd0;
        step(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
        byp_addr0 = 5'd9;
        #1;
        total++;
        if ({byp_hit0, byp_data0, byp_hit1, byp_hit2} !== {1'b1, 32'h2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bypass got hit0=%b data0=%h hit1=%b hit2=%b required 1 2 0 0",
                     byp_hit0, byp_data0, byp_hit1, byp_hit2);
        end
        drain("bypass");
    endtask
`endif

    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr0 = '0; byp_addr1 = '0; byp_addr2 = '0; byp_addr3 = '0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_pair();
        test_coalesce();
        test_x0();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
